// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: drives every input vector for HOLD cycles and counts output mismatches.
// Optional first-failure capture is enabled with the TT_SWEEP_FAIL_LOG_EN macro.
module tt_sweep_checker #(
  parameter int N_IN = 3,
  parameter int HOLD = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_mask,
  output logic [N_IN-1:0]      vec,
  input  logic                 dut_z,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt
`ifdef TT_SWEEP_FAIL_LOG_EN
  ,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic                 first_fail_vld
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [7:0]          hold_q, hold_d;
  logic [2**N_IN-1:0]  mask_q, mask_d;
  logic [N_IN:0]       err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                win_end_s;
  logic                miss_s;
`ifdef TT_SWEEP_FAIL_LOG_EN
  logic [N_IN-1:0]     ff_vec_q, ff_vec_d;
  logic                ff_vld_q, ff_vld_d;
`endif

  assign win_end_s = (hold_q == HOLD_LAST);
  assign miss_s    = (state_q == APPLY) && win_end_s && (dut_z != mask_q[vec_q]);

  // Next-state logic: abort dominates, start only matters outside APPLY.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    mask_d  = mask_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef TT_SWEEP_FAIL_LOG_EN
    ff_vec_d = ff_vec_q;
    ff_vld_d = ff_vld_q;
`endif
    if (abort) begin
      state_d = IDLE;
      vec_d   = {N_IN{1'b0}};
      hold_d  = 8'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef TT_SWEEP_FAIL_LOG_EN
      ff_vec_d = {N_IN{1'b0}};
      ff_vld_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = APPLY;
            mask_d  = exp_mask;
            vec_d   = {N_IN{1'b0}};
            hold_d  = 8'd0;
            err_d   = {(N_IN + 1){1'b0}};
            busy_d  = 1'b1;
            done_d  = 1'b0;
`ifdef TT_SWEEP_FAIL_LOG_EN
            ff_vec_d = {N_IN{1'b0}};
            ff_vld_d = 1'b0;
`endif
          end else begin
            state_d = state_q;
          end
        end
        APPLY: begin
          if (win_end_s) begin
            hold_d = 8'd0;
            if (miss_s) begin
              err_d = err_q + ERR_ONE;
            end else begin
              err_d = err_q;
            end
            // The final vector is left on the bus rather than wrapping to zero.
            if (vec_q == VEC_LAST) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              vec_d = vec_q + VEC_ONE;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          vec_d   = {N_IN{1'b0}};
          hold_d  = 8'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
`ifdef TT_SWEEP_FAIL_LOG_EN
      if (miss_s && !ff_vld_q) begin
        ff_vec_d = vec_q;
        ff_vld_d = 1'b1;
      end else begin
        ff_vld_d = ff_vld_d;
      end
`endif
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= {N_IN{1'b0}};
      hold_q  <= 8'd0;
      mask_q  <= {(2**N_IN){1'b0}};
      err_q   <= {(N_IN + 1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TT_SWEEP_FAIL_LOG_EN
      ff_vec_q <= {N_IN{1'b0}};
      ff_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TT_SWEEP_FAIL_LOG_EN
      ff_vec_q <= ff_vec_d;
      ff_vld_q <= ff_vld_d;
`endif
    end
  end

  assign vec     = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign pass    = done_q && (err_q == {(N_IN + 1){1'b0}});
`ifdef TT_SWEEP_FAIL_LOG_EN
  assign first_fail_vec = ff_vec_q;
  assign first_fail_vld = ff_vld_q;
`endif

endmodule
